axi_rom_rd_slave: RTL and testbench

//  AXI3 read-only responder in front of a synchronous single-port word memory (boot ROM / on-chip SRAM).

---
 rtl/axi_rom_rd_slave_pkg.sv | 30 +++
 rtl/axi_rd_fifo2.sv | 48 ++++
 rtl/axi_rom_rd_slave.sv | 140 ++++++++++++++
 tb/tb_axi_rom_rd_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rom_rd_slave_pkg.sv
// Shared AXI read-slave constants, FSM state type and AR legality check.
// Used by the ROM read responder and its output FIFO.
package axi_rom_rd_slave_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

    // One FIFO entry: {rdata, rlast, rresp}
    localparam int BEAT_W = 35;

    // WRAP needs len+1 to be a power of two of at least 2 beats
    function automatic logic ar_illegal(input logic [2:0] size, input logic [1:0] burst,
                                        input logic [3:0] len);
        logic wrap_bad;
        wrap_bad = (burst == AXI_BURST_WRAP) &&
                   ((len == 4'd0) || ((len & (len + 4'd1)) != 4'd0));
        return (size != AXI_SIZE_4B) || (burst == 2'd3) || wrap_bad;
    endfunction

endpackage

// File: rtl/axi_rd_fifo2.sv
// Two-entry fall-through FIFO holding read beats; an incoming beat is visible
// at the head in the same cycle it is pushed when the FIFO is empty.
module axi_rd_fifo2
    import axi_rom_rd_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [BEAT_W-1:0] din,
    output logic [BEAT_W-1:0] dout,
    output logic              valid,
    output logic [1:0]        count
);

    logic [BEAT_W-1:0] mem [0:1];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              empty;
    logic              store;
    logic              take;

    // Empty FIFO with push and pop in the same cycle passes the beat straight through
    always_comb begin
        empty = (count == 2'd0);
        valid = !empty || push;
        dout  = empty ? din : mem[rd_ptr];
        store = push && !(empty && pop);
        take  = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (store) wr_ptr <= ~wr_ptr;
            if (take)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, store} - {1'b0, take};
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_rom_rd_slave.sv
// AXI3 read-only responder for a synchronous word memory: one burst at a time,
// FIXED/INCR/WRAP addressing, SLVERR bursts for unsupported requests.
module axi_rom_rd_slave
    import axi_rom_rd_slave_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        id_q;
    logic [3:0]        len_q;
    logic [1:0]        burst_q;
    logic              err_q;
    logic [MEM_AW-1:0] waddr;
    logic [4:0]        issued;
    logic              in_flight;
    logic              in_flight_last;
    logic              ar_hs;
    logic              issue;
    logic              last_hs;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [BEAT_W-1:0] fifo_din;
    logic [BEAT_W-1:0] fifo_dout;
    logic              unused_addr;

    function automatic logic [MEM_AW-1:0] next_word(input logic [MEM_AW-1:0] w,
                                                    input logic [1:0] burst,
                                                    input logic [3:0] len);
        logic [MEM_AW-1:0] inc;
        logic [MEM_AW-1:0] mask;
        inc  = w + MEM_AW'(1);
        mask = MEM_AW'(len);
        case (burst)
            AXI_BURST_FIXED: return w;
            AXI_BURST_WRAP:  return (w & ~mask) | (inc & mask);
            default:         return inc;
        endcase
    endfunction

    assign unused_addr = ^{araddr[31:MEM_AW+2], araddr[1:0]};

    assign ar_hs   = arvalid && arready;
    assign last_hs = rvalid && rready && rlast;
    // At most two beats between memory and master, so the FIFO never overflows
    assign issue   = (state == S_BURST) &&
                     (issued < ({1'b0, len_q} + 5'd1)) &&
                     (({1'b0, fifo_count} + {2'b0, in_flight}) < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) state <= S_RESET;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_IDLE;
            S_IDLE:  if (ar_hs)   state_nxt = S_BURST;
            S_BURST: if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        arready = (state == S_IDLE);
        mem_en  = issue && !err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q           <= 4'd0;
            err_q          <= 1'b0;
            issued         <= 5'd0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_q   <= arid;
                err_q  <= ar_illegal(arsize, arburst, arlen);
                issued <= 5'd0;
            end else if (issue) begin
                issued <= issued + 5'd1;
            end
            in_flight      <= issue;
            in_flight_last <= issue && (issued == {1'b0, len_q});
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            len_q   <= arlen;
            burst_q <= arburst;
            waddr   <= araddr[MEM_AW+1:2];
        end else if (issue) begin
            waddr <= next_word(waddr, burst_q, len_q);
        end
    end

    assign mem_addr = waddr;
    // Error bursts still run the issue slots but substitute zero data
    assign fifo_din = {err_q ? 32'd0 : mem_rdata, in_flight_last,
                       err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY};

    axi_rd_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight),
        .pop   (rvalid && rready),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign rvalid = fifo_valid;
    assign rid    = id_q;
    assign {rdata, rlast, rresp} = rvalid ? fifo_dout : '0;

endmodule

// File: tb/tb_axi_rom_rd_slave.sv
// Scoreboard bench for axi_rom_rd_slave: directed AR vectors push expected beats,
// a negedge monitor pops and compares every accepted R beat.
module tb_axi_rom_rd_slave;
    localparam int MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata = 32'd0;

    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic [38:0] exp_q [$];
    logic [38:0] held;
    logic        held_v = 1'b0;
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int beats_seen = 0;
    int mem_en_cnt = 0;
    int bp_mode = 0;
    int bp_cyc = 0;
    int hs_a;
    int hs_b;

    axi_rom_rd_slave #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        exp_q.push_back({id, resp, last, data});
    endtask

    // Monitor: one scoreboard pop per accepted beat, plus AXI hold-rule check
    always @(negedge clk) begin
        logic [38:0] e;
        if (mem_en) mem_en_cnt++;
        if (held_v) begin
            check("hold_stable", {23'd0, rvalid, rid, rresp, rlast, rdata}, {23'd0, 1'b1, held});
            held_v = 1'b0;
        end
        if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", {25'd0, rid, rresp, rlast, rdata}, {25'd0, e});
            end
            beats_seen++;
            if (rlast) last_hs_cyc = cyc + 1;
        end else if (rvalid) begin
            held   = {rid, rresp, rlast, rdata};
            held_v = 1'b1;
        end
    end

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bp_cyc++;
            if (bp_mode == 0)                    rready = 1'b1;
            else if (bp_cyc >= 6 && bp_cyc < 11) rready = 1'b0;
            else                                 rready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        hs = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (arready) begin
                hs = cyc + 1;
                break;
            end
        end
        if (hs < 0) check("ar_timeout", 64'd0, 64'd1);
        else begin
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'hA500_0000 | 32'(i);
        rst = 1'b1; arvalid = 1'b0; arid = 4'd0; araddr = 32'd0;
        arlen = 4'd0; arsize = 3'd2; arburst = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {52'd0, arready, rvalid, rlast, rresp, rid, mem_en}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state_arready", 64'(arready), 64'd0);
        @(negedge clk);
        check("idle_arready", 64'(arready), 64'd1);
        @(posedge clk); #1;

        // WRAP critical-word-first, with first-beat latency
        push_exp(4'd1, 32'hA500_0007, 2'b00, 1'b0);
        for (int w = 0; w < 7; w++) push_exp(4'd1, 32'hA500_0000 | 32'(w), 2'b00, w == 6);
        do_ar(4'd1, 32'h1C, 4'd7, 3'd2, 2'd2, hs_a);
        @(negedge clk);
        check("wrap_t1_mem_en", {mem_en, rvalid}, {1'b1, 1'b0});
        check("wrap_t1_mem_addr", 64'(mem_addr), 64'h7);
        @(negedge clk);
        check("wrap_t2_rvalid", 64'(rvalid), 64'd1);
        wait_done("wrap_drain");

        // INCR and single-beat
        push_exp(4'd3, 32'hA500_0010, 2'b00, 1'b0);
        push_exp(4'd3, 32'hA500_0011, 2'b00, 1'b0);
        push_exp(4'd3, 32'hA500_0012, 2'b00, 1'b0);
        push_exp(4'd3, 32'hA500_0013, 2'b00, 1'b1);
        do_ar(4'd3, 32'h40, 4'd3, 3'd2, 2'd1, hs_a);
        wait_done("incr_drain");
        push_exp(4'd4, 32'hA500_0000, 2'b00, 1'b1);
        do_ar(4'd4, 32'h0, 4'd0, 3'd2, 2'd1, hs_a);
        wait_done("single_drain");

        // Backpressure on a WRAP burst
        bp_cyc = 0; bp_mode = 1;
        push_exp(4'd5, 32'hA500_0007, 2'b00, 1'b0);
        for (int w = 0; w < 7; w++) push_exp(4'd5, 32'hA500_0000 | 32'(w), 2'b00, w == 6);
        do_ar(4'd5, 32'h1C, 4'd7, 3'd2, 2'd2, hs_a);
        wait_done("bp_drain");
        bp_mode = 0;
        @(posedge clk); #1;

        // Error bursts: bad size, reserved burst type, WRAP with illegal length
        mem_en_cnt = 0;
        for (int b = 0; b < 4; b++) push_exp(4'd6, 32'd0, 2'b10, b == 3);
        do_ar(4'd6, 32'h100, 4'd3, 3'd3, 2'd1, hs_a);
        wait_done("err_size_drain");
        push_exp(4'd8, 32'd0, 2'b10, 1'b1);
        do_ar(4'd8, 32'h4, 4'd0, 3'd2, 2'd3, hs_a);
        wait_done("err_burst_drain");
        for (int b = 0; b < 3; b++) push_exp(4'd9, 32'd0, 2'b10, b == 2);
        do_ar(4'd9, 32'h20, 4'd2, 3'd2, 2'd2, hs_a);
        wait_done("err_wrap_drain");
        check("err_mem_en_count", 64'(mem_en_cnt), 64'd0);
        push_exp(4'd7, 32'hA500_0020, 2'b00, 1'b0);
        push_exp(4'd7, 32'hA500_0021, 2'b00, 1'b1);
        do_ar(4'd7, 32'h80, 4'd1, 3'd2, 2'd1, hs_a);
        wait_done("post_err_drain");

        // Back-to-back ARs with arvalid held
        push_exp(4'd9, 32'hA500_0080, 2'b00, 1'b0);
        push_exp(4'd9, 32'hA500_0081, 2'b00, 1'b0);
        push_exp(4'd9, 32'hA500_0082, 2'b00, 1'b0);
        push_exp(4'd9, 32'hA500_0083, 2'b00, 1'b1);
        push_exp(4'd10, 32'hA500_000E, 2'b00, 1'b0);
        push_exp(4'd10, 32'hA500_000F, 2'b00, 1'b0);
        push_exp(4'd10, 32'hA500_000C, 2'b00, 1'b0);
        push_exp(4'd10, 32'hA500_000D, 2'b00, 1'b1);
        do_ar(4'd9, 32'h200, 4'd3, 3'd2, 2'd1, hs_a);
        do_ar(4'd10, 32'h38, 4'd3, 3'd2, 2'd2, hs_b);
        check("b2b_second_ar_cycle", 64'(hs_b), 64'(last_hs_cyc + 1));
        wait_done("b2b_drain");

        // Reset during beat 3 of a WRAP len=7 burst
        beats_seen = 0;
        push_exp(4'd11, 32'hA500_0007, 2'b00, 1'b0);
        push_exp(4'd11, 32'hA500_0000, 2'b00, 1'b0);
        push_exp(4'd11, 32'hA500_0001, 2'b00, 1'b0);
        do_ar(4'd11, 32'h1C, 4'd7, 3'd2, 2'd2, hs_a);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (beats_seen >= 3) break;
        end
        check("rst_beats_before", 64'(beats_seen), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {60'd0, rvalid, arready, mem_en, rlast}, 64'd0);
        check("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_idle_arready", {62'd0, arready, rvalid}, {62'd0, 1'b1, 1'b0});
        @(posedge clk); #1;
        push_exp(4'd12, 32'hA500_0000, 2'b00, 1'b0);
        push_exp(4'd12, 32'hA500_0001, 2'b00, 1'b1);
        do_ar(4'd12, 32'h0, 4'd1, 3'd2, 2'd1, hs_a);
        wait_done("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
